// File: rtl/data_mem_sched.sv
// Write scheduler and read front-end for the 32-entry data memory: round-robin arbitration of
// two producers, registered write strobes, occupancy tracking and a valid/ack read port with
// a flush that drains every stored entry.
module data_mem_sched #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_ack,
  input  logic              flush,
  output logic              flush_done,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_write,
  output logic              mem_incr_w,
  output logic              mem_incr_r,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  typedef enum logic [1:0] {RdIdle, RdValid, Flush} rd_state_e;

  // One slot is sacrificed because the read pointer resets one ahead of the write pointer.
  localparam logic [CNT_W-1:0] MaxCount = CNT_W'(DEPTH - 1);

  rd_state_e         state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  avail_q, avail_d;
  logic              rr_last_q, rr_last_d;
  logic              wr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              wr_open, acc0, acc1, accept, pop;

  // Arbitration: the producer that did not win last gets priority on a tie.
  always_comb begin
    wr_open    = reset & ~full & (state_q != Flush);
    req0_ready = wr_open & (~req1_valid | rr_last_q);
    req1_ready = wr_open & (~req0_valid | ~rr_last_q);
    acc0       = req0_valid & req0_ready;
    acc1       = req1_valid & req1_ready;
    accept     = acc0 | acc1;
    rr_last_d  = rr_last_q;
    if (acc0) rr_last_d = 1'b0;
    if (acc1) rr_last_d = 1'b1;
  end

  // Read FSM: presents the committed head entry and sequences the flush drain.
  always_comb begin
    state_d    = state_q;
    rd_valid   = 1'b0;
    pop        = 1'b0;
    flush_done = 1'b0;
    unique case (state_q)
      RdIdle: begin
        if (flush) state_d = Flush;
        else if (avail_q != '0) state_d = RdValid;
      end
      RdValid: begin
        rd_valid = 1'b1;
        pop      = rd_ack;
        if (flush) state_d = Flush;
        // Drop to idle on the last committed entry so a same-edge commit is never read stale.
        else if (rd_ack && avail_q <= CNT_W'(1)) state_d = RdIdle;
      end
      Flush: begin
        // Let an in-flight write commit first so it is drained too.
        if (!wr_q) begin
          if (avail_q != '0) begin
            pop = 1'b1;
          end else begin
            flush_done = 1'b1;
            state_d    = RdIdle;
          end
        end
      end
      default: state_d = RdIdle;
    endcase
  end

  // Occupancy: count tracks reservations, avail tracks entries the memory has committed.
  always_comb begin
    count_d = count_q + CNT_W'(accept) - CNT_W'(pop);
    avail_d = avail_q + CNT_W'(wr_q) - CNT_W'(pop);
  end

  // State registers and the one-deep write stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RdIdle;
      count_q   <= '0;
      avail_q   <= '0;
      rr_last_q <= 1'b1;
      wr_q      <= 1'b0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      avail_q   <= avail_d;
      rr_last_q <= rr_last_d;
      wr_q      <= accept;
      if (accept) wr_data_q <= acc0 ? req0_data : req1_data;
    end
  end

  assign mem_data_in = wr_data_q;
  assign mem_write   = wr_q;
  assign mem_incr_w  = wr_q;
  assign mem_incr_r  = pop;
  assign rd_data     = mem_data_out;
  assign count       = count_q;
  assign full        = (count_q == MaxCount);
  assign empty       = (avail_q == '0);

endmodule

// File: tb/tb_data_mem_sched.sv
// Self-checking bench for data_mem_sched: behavioural memory, queue-based scoreboard fed on
// accepts and drained on pops, directed scenarios followed by randomized traffic.
module tb_data_mem_sched;
  localparam int DW    = 128;
  localparam int DEPTH = 32;
  localparam int CW    = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic [DW-1:0] req0_data = '0, req1_data = '0;
  logic          req0_ready, req1_ready;
  logic          rd_valid, rd_ack = 1'b0;
  logic [DW-1:0] rd_data;
  logic          flush = 1'b0, flush_done;
  logic [DW-1:0] mem_data_in, mem_data_out;
  logic          mem_write, mem_incr_w, mem_incr_r;
  logic [CW-1:0] count;
  logic          full, empty;

  always #5 clk = ~clk;

  data_mem_sched #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ack(rd_ack),
    .flush(flush), .flush_done(flush_done),
    .mem_data_in(mem_data_in), .mem_write(mem_write), .mem_incr_w(mem_incr_w),
    .mem_incr_r(mem_incr_r), .mem_data_out(mem_data_out),
    .count(count), .full(full), .empty(empty)
  );

  // Behavioural memory: pointers advance before access, read sees pre-write contents.
  logic [DW-1:0] mem [DEPTH];
  logic [4:0]    wptr, rptr;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr         <= 5'd0;
      rptr         <= 5'd1;
      mem_data_out <= '0;
    end else begin
      rptr         <= rptr + 5'(mem_incr_r);
      mem_data_out <= mem[rptr + 5'(mem_incr_r)];
      if (mem_write && mem_incr_w) begin
        wptr              <= wptr + 5'd1;
        mem[wptr + 5'd1]  <= mem_data_in;
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_v(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  // Reference model: FIFO of accepted entries, reserved/in-flight counts, round-robin memory.
  logic [DW-1:0] exp_q[$];
  int            count_m = 0;
  int            inflight_m = 0;
  logic [DW-1:0] inflight_d = '0;
  logic          last_m = 1'b1;
  bit            flushing_m = 1'b0;
  int            flush_pulses = 0;

  initial forever begin
    int   avail_m;
    logic a0, a1, ackpop, pop;
    @(negedge clk);
    if (!reset) begin
      exp_q.delete();
      count_m    = 0;
      inflight_m = 0;
      last_m     = 1'b1;
      flushing_m = 1'b0;
    end else begin
      avail_m = count_m - inflight_m;
      check_v("count", DW'(count), DW'(count_m));
      check_b("full", full, count_m == DEPTH - 1);
      check_b("empty", empty, avail_m == 0);
      check_b("mem_write", mem_write, inflight_m != 0);
      check_b("mem_incr_w", mem_incr_w, inflight_m != 0);
      if (inflight_m != 0) check_v("mem_data_in", mem_data_in, inflight_d);
      if (avail_m == 0) begin
        check_b("rd_valid_when_empty", rd_valid, 1'b0);
        check_b("incr_r_when_empty", mem_incr_r, 1'b0);
      end
      if (flushing_m || count_m == DEPTH - 1) begin
        check_b("ready0_blocked", req0_ready, 1'b0);
        check_b("ready1_blocked", req1_ready, 1'b0);
      end else if (req0_valid && req1_valid) begin
        check_b("arb_ready0", req0_ready, last_m);
        check_b("arb_ready1", req1_ready, !last_m);
      end else begin
        if (req0_valid) check_b("ready0", req0_ready, 1'b1);
        if (req1_valid) check_b("ready1", req1_ready, 1'b1);
      end
      if (!flushing_m) check_b("flush_done_spurious", flush_done, 1'b0);

      a0     = req0_valid & req0_ready;
      a1     = req1_valid & req1_ready;
      ackpop = rd_valid & rd_ack;
      pop    = 1'b0;
      if (!flushing_m) check_b("mem_incr_r", mem_incr_r, ackpop);
      if (ackpop) begin
        pop = 1'b1;
        if (exp_q.size() == 0) check_b("pop_with_model_empty", 1'b1, 1'b0);
        else check_v("rd_data", rd_data, exp_q.pop_front());
      end else if (mem_incr_r) begin
        pop = 1'b1;
        flush_pulses++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      flushing_m = flushing_m ? !flush_done : flush;
      if (a0 | a1) begin
        inflight_d = a0 ? req0_data : req1_data;
        exp_q.push_back(inflight_d);
        last_m = a1;
      end
      inflight_m = int'(a0 | a1);
      count_m    = count_m + int'(a0 | a1) - int'(pop);
    end
  end

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One cycle of randomized producer/consumer activity; valid is held until accepted.
  task automatic drive_cycle(input int r0, input int r1, input int ra, input int rf);
    logic acc0, acc1;
    @(negedge clk);
    acc0 = req0_valid & req0_ready;
    acc1 = req1_valid & req1_ready;
    @(posedge clk);
    #1;
    if (!req0_valid || acc0) begin
      req0_valid = int'($urandom_range(99)) < r0;
      req0_data  = rnd128();
    end
    if (!req1_valid || acc1) begin
      req1_valid = int'($urandom_range(99)) < r1;
      req1_data  = rnd128();
    end
    rd_ack = int'($urandom_range(99)) < ra;
    flush  = int'($urandom_range(99)) < rf;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    flush      = 1'b0;
    rd_ack     = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk);
      #1;
      done = (count == '0) && !mem_write && !rd_valid;
    end
    check_b("drain_completes", done, 1'b1);
    rd_ack = 1'b0;
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #2;
    reset = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rd_ack = 1'b0;
    flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] a, b;
    bit seen;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Reset mid-write clears everything without a clock edge.
    req0_valid = 1'b1;
    req0_data  = rnd128();
    @(posedge clk);
    #1;
    check_b("pre_reset_mem_write", mem_write, 1'b1);
    reset = 1'b0;
    #1;
    check_b("rst_mem_write", mem_write, 1'b0);
    check_b("rst_mem_incr_w", mem_incr_w, 1'b0);
    check_b("rst_mem_incr_r", mem_incr_r, 1'b0);
    check_b("rst_rd_valid", rd_valid, 1'b0);
    check_b("rst_flush_done", flush_done, 1'b0);
    check_b("rst_ready0", req0_ready, 1'b0);
    check_b("rst_ready1", req1_ready, 1'b0);
    check_b("rst_full", full, 1'b0);
    check_b("rst_empty", empty, 1'b1);
    check_v("rst_count", DW'(count), '0);
    check_v("rst_mem_data_in", mem_data_in, '0);
    req0_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Single path: two writes, read latency and head advance.
    a = rnd128();
    b = rnd128();
    req0_valid = 1'b1;
    req0_data  = a;
    @(posedge clk);
    #1;
    req0_data = b;
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    check_b("sp_not_valid_yet", rd_valid, 1'b0);
    @(posedge clk);
    #1;
    check_b("sp_valid_a", rd_valid, 1'b1);
    check_v("sp_data_a", rd_data, a);
    rd_ack = 1'b1;
    @(posedge clk);
    #1;
    check_b("sp_valid_b", rd_valid, 1'b1);
    check_v("sp_data_b", rd_data, b);
    @(posedge clk);
    #1;
    rd_ack = 1'b0;
    check_b("sp_end_valid", rd_valid, 1'b0);
    check_b("sp_end_empty", empty, 1'b1);

    // Arbitration: both producers held valid alternate starting with req0.
    reset_dut();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data  = rnd128();
    req1_data  = rnd128();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_b("rr_grant0", req0_ready, (i % 2) == 0);
      check_b("rr_grant1", req1_ready, (i % 2) == 1);
      @(posedge clk);
      #1;
      if (i % 2 == 0) req0_data = rnd128();
      else req1_data = rnd128();
    end
    drain();

    // Full: fill with no reads, then a single pop reopens the write side.
    for (int i = 0; i < 40; i++) drive_cycle(100, 0, 0, 0);
    @(negedge clk);
    check_b("full_flag", full, 1'b1);
    check_v("full_count", DW'(count), DW'(DEPTH - 1));
    check_b("full_ready0", req0_ready, 1'b0);
    @(posedge clk);
    #1;
    rd_ack = 1'b1;
    @(posedge clk);
    #1;
    rd_ack = 1'b0;
    check_b("full_ready_returns", req0_ready, 1'b1);
    check_b("full_cleared", full, 1'b0);
    drain();

    // Concurrency: one write and one pop per cycle keeps occupancy constant.
    for (int i = 0; i < 10; i++) drive_cycle(100, 0, 100, 0);
    for (int i = 0; i < 20; i++) begin
      drive_cycle(100, 0, 100, 0);
      check_v("steady_count", DW'(count), DW'(3));
    end
    drain();

    // Flush with five stored entries and a sixth write in flight.
    req0_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req0_data = rnd128();
      @(posedge clk);
      #1;
    end
    req0_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    flush_pulses = 0;
    req0_valid = 1'b1;
    req0_data  = rnd128();
    flush      = 1'b1;
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    flush      = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (flush_done) begin
        seen = 1'b1;
        check_v("flush_pulses", DW'(flush_pulses), DW'(6));
        check_v("flush_count", DW'(count), '0);
        check_b("flush_empty", empty, 1'b1);
      end
    end
    check_b("flush_done_seen", seen, 1'b1);
    @(posedge clk);
    #1;

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 400; i++) drive_cycle(55, 45, 40, 2);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
